// File: rtl/rf_writeback_ctrl.sv
// Write-back controller: merges ALU and buffered load results into the
// register-file write port and tracks outstanding loads per register.
// Ports: CLK/reset (sync, active-high); alu_wen/alu_addr/alu_data ALU
// result; ld_issue/ld_issue_addr load issue; ld_valid/ld_ready/ld_addr/
// ld_data load result handshake; q_rs/q_rd -> hazard decode query;
// regWrite/writeAddr/writeValue registered write port; fifo_count
// occupancy; waw_err sticky write-after-write flag.
// Optional macro WB_BYPASS_EN: a load arriving with the FIFO empty and no
// ALU write skips the FIFO and reaches the write port one cycle later.
module rf_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     alu_wen,
  input  logic [2:0]               alu_addr,
  input  logic [7:0]               alu_data,
  input  logic                     ld_issue,
  input  logic [2:0]               ld_issue_addr,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [2:0]               ld_addr,
  input  logic [7:0]               ld_data,
  input  logic [2:0]               q_rs,
  input  logic [2:0]               q_rd,
  output logic                     hazard,
  output logic                     regWrite,
  output logic [2:0]               writeAddr,
  output logic [7:0]               writeValue,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     waw_err
);

  localparam int AW = $clog2(DEPTH);

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] pend [8];

  logic        full;
  logic        empty;
  logic        xfer;
  logic        byp;
  logic        push;
  logic        pop;
  logic [2:0]  head_addr;
  logic [7:0]  head_data;
  logic        dec;
  logic [2:0]  dec_addr;
  logic        inc;

  assign full      = (fifo_count == DEPTH[AW:0]);
  assign empty     = (fifo_count == '0);
  assign ld_ready  = !full;
  assign xfer      = ld_valid && ld_ready;
  assign head_addr = mem[rptr][10:8];
  assign head_data = mem[rptr][7:0];

`ifdef WB_BYPASS_EN
  assign byp = xfer && empty && !alu_wen;
`else
  assign byp = 1'b0;
`endif

  assign push = xfer && !byp;
  assign pop  = !alu_wen && !empty;

  // A load leaving for the write port retires its scoreboard entry.
  always_comb begin
    dec      = 1'b0;
    dec_addr = 3'd0;
    if (pop) begin
      dec      = 1'b1;
      dec_addr = head_addr;
    end else if (byp) begin
      dec      = 1'b1;
      dec_addr = ld_addr;
    end
  end

  assign inc = ld_issue && (ld_issue_addr != 3'd0);

  assign hazard = ((q_rs != 3'd0) && (pend[q_rs] != '0)) ||
                  ((q_rd != 3'd0) && (pend[q_rd] != '0));

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {ld_addr, ld_data};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Writes to register 0 are consumed without asserting regWrite.
  always_ff @(posedge CLK) begin
    if (reset) begin
      regWrite   <= 1'b0;
      writeAddr  <= 3'd0;
      writeValue <= 8'd0;
    end else begin
      unique case (1'b1)
        alu_wen: begin
          regWrite   <= (alu_addr != 3'd0);
          writeAddr  <= alu_addr;
          writeValue <= alu_data;
        end
        pop: begin
          regWrite   <= (head_addr != 3'd0);
          writeAddr  <= head_addr;
          writeValue <= head_data;
        end
        byp: begin
          regWrite   <= (ld_addr != 3'd0);
          writeAddr  <= ld_addr;
          writeValue <= ld_data;
        end
        default: regWrite <= 1'b0;
      endcase
    end
  end

  // Saturating counters; a coincident issue and retire cancel out.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) pend[i] <= '0;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (inc && (ld_issue_addr == 3'(i)) &&
            !(dec && (dec_addr == 3'(i)))) begin
          if (pend[i] != '1) pend[i] <= pend[i] + 1'b1;
        end else if (dec && (dec_addr == 3'(i)) &&
                     !(inc && (ld_issue_addr == 3'(i)))) begin
          if (pend[i] != '0) pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      waw_err <= 1'b0;
    end else if (alu_wen && (alu_addr != 3'd0) &&
                 (pend[alu_addr] != '0)) begin
      waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed testbench for rf_writeback_ctrl.
// Ports: none; drives the DUT and prints a one-line summary.
module tb_rf_writeback_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic       alu_wen;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       ld_issue;
  logic [2:0] ld_issue_addr;
  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] q_rs;
  logic [2:0] q_rd;
  logic       hazard;
  logic       regWrite;
  logic [2:0] writeAddr;
  logic [7:0] writeValue;
  logic [2:0] fifo_count;
  logic       waw_err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rf_writeback_ctrl #(.DEPTH(4), .CW(3)) dut (
    .CLK(CLK), .reset(reset),
    .alu_wen(alu_wen), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .q_rs(q_rs), .q_rd(q_rd), .hazard(hazard),
    .regWrite(regWrite), .writeAddr(writeAddr),
    .writeValue(writeValue), .fifo_count(fifo_count),
    .waw_err(waw_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alu_wen = 0; alu_addr = 0; alu_data = 0;
    ld_issue = 0; ld_issue_addr = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    idle(); q_rs = 0; q_rd = 0;
    reset = 1; step(); step(); reset = 0;
    total++;
    if ({regWrite, writeAddr, writeValue} !== 12'h0) begin
      bad++;
      $display("FAIL reset_out: got %0b/%0h/%0h expected 0/0/0",
               regWrite, writeAddr, writeValue);
    end
    total++;
    if (fifo_count !== 3'd0 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_fifo: got cnt=%0d rdy=%0b expected 0/1",
               fifo_count, ld_ready);
    end
    total++;
    if (waw_err !== 1'b0 || hazard !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got waw=%0b hz=%0b expected 0/0",
               waw_err, hazard);
    end
  endtask

  task automatic test_alu();
    alu_wen = 1; alu_addr = 3; alu_data = 8'h5A;
    step(); idle();
    total++;
    if ({regWrite, writeAddr, writeValue} !== {1'b1, 3'd3, 8'h5A}) begin
      bad++;
      $display("FAIL alu_write: got %0b/%0h/%0h expected 1/3/5a",
               regWrite, writeAddr, writeValue);
    end
    step();
    total++;
    if (regWrite !== 1'b0) begin
      bad++;
      $display("FAIL alu_idle: got %0b expected 0", regWrite);
    end
  endtask

  task automatic test_load();
    q_rs = 5;
    ld_issue = 1; ld_issue_addr = 5;
    step(); idle();
    total++;
    if (hazard !== 1'b1) begin
      bad++;
      $display("FAIL load_hz_issue: got %0b expected 1", hazard);
    end
    ld_valid = 1; ld_addr = 5; ld_data = 8'h77;
    step(); idle();
`ifndef WB_BYPASS_EN
    total++;
    if (regWrite !== 1'b0 || hazard !== 1'b1) begin
      bad++;
      $display("FAIL load_wait: got rw=%0b hz=%0b expected 0/1",
               regWrite, hazard);
    end
    step();
`endif
    total++;
    if ({regWrite, writeAddr, writeValue} !== {1'b1, 3'd5, 8'h77}) begin
      bad++;
      $display("FAIL load_write: got %0b/%0h/%0h expected 1/5/77",
               regWrite, writeAddr, writeValue);
    end
    total++;
    if (hazard !== 1'b0) begin
      bad++;
      $display("FAIL load_hz_retire: got %0b expected 0", hazard);
    end
    q_rs = 0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      alu_wen = 1; alu_addr = 7; alu_data = 8'(8'hA0 + i);
      ld_valid = (i < 5);
      ld_addr  = (i < 4) ? 3'(i + 1) : 3'd6;
      ld_data  = (i < 4) ? 8'(8'h10 + i) : 8'hEE;
      step();
      total++;
      if ({regWrite, writeAddr, writeValue} !==
          {1'b1, 3'd7, 8'(8'hA0 + i)}) begin
        bad++;
        $display("FAIL fill_alu%0d: got %0b/%0h/%0h expected 1/7/%0h",
                 i, regWrite, writeAddr, writeValue, 8'hA0 + i);
      end
      if (i >= 3) begin
        total++;
        if (fifo_count !== 3'd4 || ld_ready !== 1'b0) begin
          bad++;
          $display("FAIL fill_full%0d: got cnt=%0d rdy=%0b expected 4/0",
                   i, fifo_count, ld_ready);
        end
      end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({regWrite, writeAddr, writeValue} !==
          {1'b1, 3'(k + 1), 8'(8'h10 + k)}) begin
        bad++;
        $display("FAIL drain%0d: got %0b/%0h/%0h expected 1/%0h/%0h",
                 k, regWrite, writeAddr, writeValue, k + 1, 8'h10 + k);
      end
    end
    total++;
    if (fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: got %0d expected 0", fifo_count);
    end
    step();
  endtask

  task automatic test_reg0();
    q_rd = 0;
    alu_wen = 1; alu_addr = 0; alu_data = 8'h11;
    ld_issue = 1; ld_issue_addr = 0;
    step(); idle();
    total++;
    if (regWrite !== 1'b0) begin
      bad++;
      $display("FAIL reg0_alu: got %0b expected 0", regWrite);
    end
    ld_valid = 1; ld_addr = 0; ld_data = 8'h22;
    step(); idle();
    total++;
    if (regWrite !== 1'b0) begin
      bad++;
      $display("FAIL reg0_ld1: got %0b expected 0", regWrite);
    end
    step();
    total++;
    if (regWrite !== 1'b0 || fifo_count !== 3'd0 || hazard !== 1'b0) begin
      bad++;
      $display("FAIL reg0_ld2: got rw=%0b cnt=%0d hz=%0b expected 0/0/0",
               regWrite, fifo_count, hazard);
    end
  endtask

  task automatic test_waw();
    ld_issue = 1; ld_issue_addr = 2;
    step(); idle();
    alu_wen = 1; alu_addr = 2; alu_data = 8'h33;
    step(); idle();
    total++;
    if (waw_err !== 1'b1) begin
      bad++;
      $display("FAIL waw_set: got %0b expected 1", waw_err);
    end
    total++;
    if ({regWrite, writeAddr, writeValue} !== {1'b1, 3'd2, 8'h33}) begin
      bad++;
      $display("FAIL waw_write: got %0b/%0h/%0h expected 1/2/33",
               regWrite, writeAddr, writeValue);
    end
    step(); step();
    total++;
    if (waw_err !== 1'b1) begin
      bad++;
      $display("FAIL waw_sticky: got %0b expected 1", waw_err);
    end
  endtask

  task automatic test_reset_mid();
    q_rs = 6;
    alu_wen = 1; alu_addr = 1; alu_data = 8'h01;
    ld_issue = 1; ld_issue_addr = 6;
    ld_valid = 1; ld_addr = 6; ld_data = 8'h61;
    step();
    ld_data = 8'h62;
    step();
    ld_issue = 0; ld_addr = 4; ld_data = 8'h41;
    step();
    total++;
    if (fifo_count !== 3'd3 || hazard !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got cnt=%0d hz=%0b expected 3/1",
               fifo_count, hazard);
    end
    idle();
    reset = 1;
    step();
    reset = 0;
    total++;
    if (fifo_count !== 3'd0 || hazard !== 1'b0 || regWrite !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got cnt=%0d hz=%0b rw=%0b expected 0/0/0",
               fifo_count, hazard, regWrite);
    end
    total++;
    if (waw_err !== 1'b0 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_flags: got waw=%0b rdy=%0b expected 0/1",
               waw_err, ld_ready);
    end
    step();
    total++;
    if (regWrite !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL mid_after: got rw=%0b cnt=%0d expected 0/0",
               regWrite, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_fill();
    test_reg0();
    test_waw();
    test_reset_mid();
    chk("final_ready", ld_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
